// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame streamer: FSM states,
// default one-wire timing at 50 MHz and the GRB pixel field layout.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    LATCH,
    DONE
  } led_state_e;

  // 20 ns clock: 0.4 us / 0.8 us high, 1.26 us bit, 50 us latch
  localparam int DEF_T0H    = 20;
  localparam int DEF_T1H    = 40;
  localparam int DEF_TBIT   = 63;
  localparam int DEF_TLATCH = 2500;

  localparam int PIX_BITS = 24;
  localparam int G_HI = 23;
  localparam int G_LO = 16;
  localparam int R_HI = 15;
  localparam int R_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Shapes one NRZ bit: a load starts a TBIT-cycle period whose high phase
// length depends on the bit; bit_end marks the last cycle of the period.
module ws2812_bit_encoder
  import led_pkg::*;
#(
  parameter int T0H  = DEF_T0H,
  parameter int T1H  = DEF_T1H,
  parameter int TBIT = DEF_TBIT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic tx_bit,
  output logic led_out,
  output logic bit_end
);

  localparam int CW = cnt_width(TBIT);
  localparam logic [CW-1:0] LAST = CW'(TBIT - 1);
  localparam logic [CW-1:0] HI0  = CW'(T0H);
  localparam logic [CW-1:0] HI1  = CW'(T1H);

  logic          active_reg;
  logic          bit_reg;
  logic          led_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] thr_load;
  logic [CW-1:0] thr_run;

  assign cnt_next = cnt_reg + 1'b1;
  assign thr_load = tx_bit ? HI1 : HI0;
  assign thr_run  = bit_reg ? HI1 : HI0;
  assign bit_end  = active_reg && (cnt_reg == LAST);
  assign led_out  = led_reg;

  // led_reg is computed for the counter value of the following cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_reg <= 1'b0;
      bit_reg    <= 1'b0;
      led_reg    <= 1'b0;
      cnt_reg    <= '0;
    end else if (load) begin
      active_reg <= 1'b1;
      bit_reg    <= tx_bit;
      cnt_reg    <= '0;
      led_reg    <= (thr_load != '0);
    end else if (active_reg) begin
      if (cnt_reg == LAST) begin
        active_reg <= 1'b0;
        cnt_reg    <= '0;
        led_reg    <= 1'b0;
      end else begin
        cnt_reg <= cnt_next;
        led_reg <= (cnt_next < thr_run);
      end
    end
  end

endmodule

// File: rtl/led_frame_streamer.sv
// Reads NUM_LEDS pixels from the frame RAM and streams them as one-wire NRZ,
// followed by a low latch interval and a one-cycle done pulse.
module led_frame_streamer
  import led_pkg::*;
#(
  parameter int SIZE     = 4,
  parameter int NUM_LEDS = 16,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int TBIT     = DEF_TBIT,
  parameter int TLATCH   = DEF_TLATCH
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            ram_sel,
  output logic            ram_we,
  output logic [SIZE-1:0] ram_adr,
  input  logic [63:0]     ram_dat_i,
  output logic            led_out
);

  localparam int BCW = $clog2(PIX_BITS);
  localparam int LCW = cnt_width(TLATCH);
  localparam logic [SIZE:0]   LAST_PIX   = (SIZE + 1)'(NUM_LEDS - 1);
  localparam logic [LCW-1:0]  LAST_LATCH = LCW'(TLATCH - 1);
  localparam logic [BCW-1:0]  FIRST_BIT  = BCW'(PIX_BITS - 1);

  led_state_e          state_reg;
  logic [SIZE:0]       pix_reg;
  logic [BCW-1:0]      bitcnt_reg;
  logic [PIX_BITS-1:0] shift_reg;
  logic [LCW-1:0]      latch_cnt_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                ram_sel_reg;
  logic [SIZE-1:0]     ram_adr_reg;

  logic enc_load;
  logic enc_bit;
  logic bit_end;
  logic unused_upper;

  assign unused_upper = ^ram_dat_i[63:PIX_BITS];

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign ram_sel = ram_sel_reg;
  assign ram_we  = 1'b0;
  assign ram_adr = ram_adr_reg;

  // First bit comes straight from the RAM in LOAD so it starts right after LOAD
  assign enc_load = (state_reg == LOAD) ||
                    ((state_reg == SEND) && bit_end && (bitcnt_reg != '0));
  assign enc_bit  = (state_reg == LOAD) ? ram_dat_i[G_HI] : shift_reg[PIX_BITS-2];

  ws2812_bit_encoder #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_encoder (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (enc_load),
    .tx_bit  (enc_bit),
    .led_out (led_out),
    .bit_end (bit_end)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      pix_reg       <= '0;
      bitcnt_reg    <= '0;
      shift_reg     <= '0;
      latch_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      ram_sel_reg   <= 1'b0;
      ram_adr_reg   <= '0;
    end else begin
      done_reg    <= 1'b0;
      ram_sel_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= FETCH;
            pix_reg     <= '0;
            ram_adr_reg <= '0;
            ram_sel_reg <= 1'b1;
            busy_reg    <= 1'b1;
          end
        end
        FETCH: state_reg <= LOAD;
        LOAD: begin
          shift_reg  <= {ram_dat_i[G_HI:G_LO], ram_dat_i[R_HI:R_LO], ram_dat_i[B_HI:B_LO]};
          bitcnt_reg <= FIRST_BIT;
          state_reg  <= SEND;
        end
        SEND: begin
          if (bit_end) begin
            if (bitcnt_reg != '0) begin
              shift_reg  <= {shift_reg[PIX_BITS-2:0], 1'b0};
              bitcnt_reg <= bitcnt_reg - 1'b1;
            end else if (pix_reg != LAST_PIX) begin
              pix_reg     <= pix_reg + 1'b1;
              ram_adr_reg <= pix_reg[SIZE-1:0] + 1'b1;
              ram_sel_reg <= 1'b1;
              state_reg   <= FETCH;
            end else begin
              latch_cnt_reg <= '0;
              state_reg     <= LATCH;
            end
          end
        end
        LATCH: begin
          if (latch_cnt_reg == LAST_LATCH) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end else begin
            latch_cnt_reg <= latch_cnt_reg + 1'b1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_streamer.sv
// Scoreboard bench: a one-pixel instance at default timing and a 16-pixel
// instance at compressed timing, each with a registered-read RAM model.
module tb_led_frame_streamer;
  import led_pkg::*;

  localparam int SIZE     = 4;
  localparam int B_LEDS   = 16;
  localparam int B_T0H    = 2;
  localparam int B_T1H    = 4;
  localparam int B_TBIT   = 6;
  localparam int B_TLATCH = 20;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic            busy_a, done_a, sel_a, we_a, led_a;
  logic [SIZE-1:0] adr_a;
  logic [63:0]     dat_a;
  logic            busy_b, done_b, sel_b, we_b, led_b;
  logic [SIZE-1:0] adr_b;
  logic [63:0]     dat_b;
  logic [63:0]     mem_a [0:15];
  logic [63:0]     mem_b [0:15];

  always @(posedge clock) if (sel_a) dat_a <= mem_a[adr_a];
  always @(posedge clock) if (sel_b) dat_b <= mem_b[adr_b];

  led_frame_streamer #(.SIZE(SIZE), .NUM_LEDS(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .busy(busy_a), .done(done_a),
    .ram_sel(sel_a), .ram_we(we_a), .ram_adr(adr_a), .ram_dat_i(dat_a), .led_out(led_a)
  );

  led_frame_streamer #(.SIZE(SIZE), .NUM_LEDS(B_LEDS), .T0H(B_T0H), .T1H(B_T1H),
                       .TBIT(B_TBIT), .TLATCH(B_TLATCH)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
    .ram_sel(sel_b), .ram_we(we_b), .ram_adr(adr_b), .ram_dat_i(dat_b), .led_out(led_b)
  );

  int checks = 0;
  int failures = 0;
  bit we_seen = 1'b0;

  int q_w_a[$], q_per_a[$], q_adr_a[$], q_done_a[$];
  int q_gap_b[$], q_pix_b[$], q_adr_b[$], q_done_b[$];

  // 24'hA50F81 sent MSB first
  int widths_a [24] = '{40,20,40,20,20,40,20,40, 20,20,20,20,40,40,40,40,
                        40,20,20,20,20,20,20,40};

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) cycle=%0d",
               name, act, act, exp, exp, cyc);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected-or-missing-event required=scoreboard-entry cycle=%0d",
             name, cyc);
  endfunction

  // Monitor for instance A: high widths, bit periods, address and done timing
  initial begin
    bit prev, have, dprev;
    int hi, last;
    prev = 0; have = 0; dprev = 0; hi = 0; last = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev = 0; have = 0; dprev = 0; hi = 0;
      end else begin
        if (led_a && !prev) begin
          if (have) begin
            if (q_per_a.size() == 0) fail("period_a");
            else check("period_a", cyc - last, q_per_a.pop_front());
          end
          have = 1; last = cyc; hi = 0;
        end
        if (led_a) hi++;
        if (!led_a && prev) begin
          if (q_w_a.size() == 0) fail("width_a");
          else check("width_a", hi, q_w_a.pop_front());
        end
        if (sel_a) begin
          if (q_adr_a.size() == 0) fail("adr_a");
          else check("adr_a", int'(adr_a), q_adr_a.pop_front());
        end
        if (we_a) we_seen = 1'b1;
        if (dprev) check("done_a_pulse_width", int'(done_a), 0);
        if (done_a) begin
          if (q_done_a.size() == 0) fail("done_a");
          else check("done_a_cycle", cyc, q_done_a.pop_front());
          check("busy_at_done_a", int'(busy_a), 0);
          $display("frame A done at cycle %0d", cyc);
          have = 0;
        end
        prev = led_a; dprev = done_a;
      end
    end
  end

  // Monitor for instance B: decodes pixels and checks gaps, addresses, done
  initial begin
    bit prev, have, dprev, bv;
    int hi, last, nbits, npix;
    logic [23:0] acc;
    prev = 0; have = 0; dprev = 0; hi = 0; last = 0; nbits = 0; npix = 0; acc = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev = 0; have = 0; dprev = 0; hi = 0; nbits = 0; npix = 0; acc = '0;
      end else begin
        if (led_b && !prev) begin
          if (have) begin
            if (q_gap_b.size() == 0) fail("gap_b");
            else check("gap_b", cyc - last, q_gap_b.pop_front());
          end
          have = 1; last = cyc; hi = 0;
        end
        if (led_b) hi++;
        if (!led_b && prev) begin
          bv = (hi > (B_T0H + B_T1H) / 2);
          check("width_b", hi, bv ? B_T1H : B_T0H);
          acc = {acc[22:0], bv};
          nbits++;
          if (nbits == 24) begin
            if (q_pix_b.size() == 0) fail("pixel_b");
            else check("pixel_b", int'(acc), q_pix_b.pop_front());
            $display("B pixel %0d data=%06h", npix, acc);
            nbits = 0; npix++;
          end
        end
        if (sel_b) begin
          if (q_adr_b.size() == 0) fail("adr_b");
          else check("adr_b", int'(adr_b), q_adr_b.pop_front());
        end
        if (we_b) we_seen = 1'b1;
        if (dprev) check("done_b_pulse_width", int'(done_b), 0);
        if (done_b) begin
          if (q_done_b.size() == 0) fail("done_b");
          else check("done_b_cycle", cyc, q_done_b.pop_front());
          check("busy_at_done_b", int'(busy_b), 0);
          check("bits_left_at_done_b", nbits, 0);
          $display("frame B done at cycle %0d pixels=%0d", cyc, npix);
          have = 0; npix = 0;
        end
        prev = led_b; dprev = done_b;
      end
    end
  end

  task automatic wait_done_b(input string tag);
    for (int n = 0; n < 6000; n++) begin
      @(negedge clock);
      if (done_b) return;
    end
    fail(tag);
  endtask

  task automatic wait_sel_b(input int a, input string tag);
    for (int n = 0; n < 6000; n++) begin
      @(negedge clock);
      if (sel_b && int'(adr_b) == a) return;
    end
    fail(tag);
  endtask

  task automatic pulse_start_b();
    @(posedge clock); #1 start_b = 1'b1;
    @(posedge clock); #1 start_b = 1'b0;
  endtask

  task automatic start_frame_b();
    int s;
    for (int i = 0; i < B_LEDS; i++) begin
      q_adr_b.push_back(i);
      q_pix_b.push_back(int'(mem_b[i][23:0]));
      for (int k = 0; k < 24; k++)
        if (i > 0 || k > 0) q_gap_b.push_back((k == 0) ? B_TBIT + 2 : B_TBIT);
    end
    @(posedge clock); #1 start_b = 1'b1;
    s = cyc;
    q_done_b.push_back(s + 1 + B_LEDS * (24 * B_TBIT + 2) + B_TLATCH);
    @(posedge clock); #1 start_b = 1'b0;
    check("fetch_sel_after_start_b", int'(sel_b), 1);
    check("fetch_adr_after_start_b", int'(adr_b), 0);
    check("busy_after_start_b", int'(busy_b), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=still-running required=finished cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 64'h0;
      mem_b[i] = 64'(i);
    end

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_led_a", int'(led_a), 0);
    check("reset_busy_a", int'(busy_a), 0);
    check("reset_sel_a", int'(sel_a), 0);
    check("reset_adr_a", int'(adr_a), 0);
    check("reset_led_b", int'(led_b), 0);
    check("reset_busy_b", int'(busy_b), 0);
    check("reset_done_b", int'(done_b), 0);
    check("reset_we_b", int'(we_b), 0);
    @(negedge clock); #2 reset_n = 1'b1;

    // Idle for 100 cycles with start low
    repeat (100) @(posedge clock);
    #1;
    check("idle_led_a", int'(led_a), 0);
    check("idle_busy_a", int'(busy_a), 0);
    check("idle_sel_a", int'(sel_a), 0);
    check("idle_led_b", int'(led_b), 0);
    check("idle_busy_b", int'(busy_b), 0);
    check("idle_sel_b", int'(sel_b), 0);

    // Single pixel at default timing
    mem_a[0] = 64'hFFFF_FFFF_00A5_0F81;
    for (int i = 0; i < 24; i++) q_w_a.push_back(widths_a[i]);
    for (int i = 0; i < 23; i++) q_per_a.push_back(63);
    q_adr_a.push_back(0);
    @(posedge clock); #1 start_a = 1'b1;
    s = cyc;
    // done high in cycle s+4015, falling 4016 cycles after start
    q_done_a.push_back(s + 1 + 1514 + 2500);
    @(posedge clock); #1 start_a = 1'b0;
    check("fetch_sel_after_start_a", int'(sel_a), 1);
    check("busy_after_start_a", int'(busy_a), 1);
    begin : wait_a
      for (int n = 0; n < 6000; n++) begin
        @(negedge clock);
        if (done_a) disable wait_a;
      end
      fail("timeout_done_a");
    end
    repeat (2) @(posedge clock);

    // Full frame, RAM[i] = i
    start_frame_b();
    wait_done_b("timeout_frame1_b");

    // start while busy at pixel 3 and during LATCH, then during DONE
    for (int i = 0; i < 16; i++)
      mem_b[i] = {40'hDE_ADBE_EF00, 8'h80 | 8'(i), 8'h3C, 8'hF0 - 8'(i)};
    start_frame_b();
    wait_sel_b(3, "timeout_pix3_b");
    pulse_start_b();
    wait_sel_b(15, "timeout_pix15_b");
    repeat (150) @(posedge clock);
    #1 check("busy_in_latch_b", int'(busy_b), 1);
    start_b = 1'b1;
    @(posedge clock); #1 start_b = 1'b0;
    wait_done_b("timeout_frame2_b");
    start_b = 1'b1;
    @(posedge clock); #1 start_b = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("start_in_done_ignored_busy_b", int'(busy_b), 0);
    check("start_in_done_ignored_sel_b", int'(sel_b), 0);

    // Back-to-back frames: start in the IDLE cycle right after done
    for (int i = 0; i < 16; i++) mem_b[i] = {40'h0, 24'h5A_A500 ^ 24'(i * 24'h010203)};
    start_frame_b();
    wait_done_b("timeout_frame3_b");
    start_frame_b();
    wait_done_b("timeout_frame4_b");

    // Reset during the high phase of pixel 5, bit 10
    mem_b[5] = 64'h0123_4567_89FF_FFFF;
    start_frame_b();
    wait_sel_b(5, "timeout_pix5_b");
    repeat (63) @(negedge clock);
    check("led_high_before_reset_b", int'(led_b), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_led_b", int'(led_b), 0);
    check("async_reset_busy_b", int'(busy_b), 0);
    check("async_reset_done_b", int'(done_b), 0);
    q_gap_b.delete(); q_pix_b.delete(); q_adr_b.delete(); q_done_b.delete();
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1 check("no_done_after_abort_b", int'(done_b), 0);

    // New frame after the abort restarts at address 0
    start_frame_b();
    wait_done_b("timeout_frame6_b");
    repeat (3) @(posedge clock);

    check("left_adr_a", q_adr_a.size(), 0);
    check("left_width_a", q_w_a.size(), 0);
    check("left_done_a", q_done_a.size(), 0);
    check("left_adr_b", q_adr_b.size(), 0);
    check("left_pix_b", q_pix_b.size(), 0);
    check("left_gap_b", q_gap_b.size(), 0);
    check("left_done_b", q_done_b.size(), 0);
    check("ram_we_never_high", int'(we_seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_frame_streamer.md
Name: led_frame_streamer

Overview:
- Downstream consumer of the 64-bit pixel RAM: on a start pulse, walks RAM words 0..NUM_LEDS-1 over the RAM's sel/we/adr read port.
- Serializes each pixel as WS2812-style one-wire NRZ on led_out, MSB first.
- Ends each frame with a latch (low) interval, then pulses done.
- Sits between the frame RAM and the LED strip pad.

Parameters:
- SIZE, 4: RAM address width; must match the RAM's SIZE.
- NUM_LEDS, 16: pixels per frame, 1..2^SIZE.
- T0H, 20: clock cycles led_out is high for a 0 bit.
- T1H, 40: clock cycles led_out is high for a 1 bit.
- TBIT, 63: total clock cycles per bit. Constraint: T0H < T1H < TBIT.
- TLATCH, 2500: clock cycles led_out is held low after the last bit.

Ports:
- clock, input, 1: single system clock; all logic on posedge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle request to send a frame; sampled only in IDLE.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle pulse when the latch interval ends.
- ram_sel, output, 1: RAM select.
- ram_we, output, 1: RAM write enable; tied 0.
- ram_adr, output, SIZE: pixel address.
- ram_dat_i, input, 64: RAM read data; valid the cycle after ram_sel is high.
- led_out, output, 1: serial data to the strip.

Behaviour:
- Reset (async assert, any state): state=IDLE; led_out=0, busy=0, done=0, ram_sel=0, ram_we=0, ram_adr=0; all counters and the shift register cleared.
- Reset mid-frame aborts immediately. No done pulse. led_out falls low at once.
- Pixel format: ram_dat_i[23:0] = {G[7:0], R[7:0], B[7:0]}. Bits [63:24] are ignored. Transmit bit 23 first.
- States:
  - IDLE: all outputs low. If start=1, go to FETCH with pix=0 and busy=1.
  - FETCH (1 cycle): ram_sel=1, ram_adr=pix. Go to LOAD.
  - LOAD (1 cycle): ram_sel=0. Capture ram_dat_i[23:0] into the 24-bit shift register, bitcnt=23. Go to SEND.
  - SEND:
    - Per bit, a cycle counter runs 0..TBIT-1.
    - led_out=1 while counter < (bit ? T1H : T0H), else 0.
    - At counter=TBIT-1: if bitcnt>0, shift left and decrement bitcnt. Otherwise:
      - if pix<NUM_LEDS-1, increment pix and go to FETCH;
      - if pix=NUM_LEDS-1, go to LATCH.
  - LATCH: led_out=0 for TLATCH cycles. On the last cycle, go to DONE.
  - DONE (1 cycle): done=1, busy=0 that same cycle. Go to IDLE.
- led_out is registered. In SEND its first high cycle is the cycle after LOAD.
- Pixel period is exactly 24*TBIT+2 cycles; the 2-cycle FETCH/LOAD gap is low.
- Frame length start-to-done: 1 + NUM_LEDS*(24*TBIT+2) + TLATCH + 1 cycles.
- start outside IDLE (including DONE) is ignored; it is not queued.
- start in the cycle after DONE (IDLE) is accepted, so back-to-back frames are legal.
- ram_adr holds its last value when ram_sel=0. The RAM ignores it.
- Exactly one ram_sel pulse per pixel. ram_we is never asserted.
- Counter widths: clog2(TBIT), clog2(TLATCH), SIZE+1 for pix. No wrap-around beyond NUM_LEDS-1.

Decomposition:
- Package led_pkg holds:
  - the state enum: IDLE, FETCH, LOAD, SEND, LATCH, DONE;
  - default timing constants T0H/T1H/TBIT/TLATCH for a 50 MHz clock;
  - the pixel field offsets: G=23:16, R=15:8, B=7:0.
- One sub-module, ws2812_bit_encoder: takes bit and a load strobe; produces led_out and a bit_end strobe. It owns the TBIT cycle counter.
- The top module keeps the FSM, pixel/bit counters, shift register and RAM interface.

Test Plan:
- Reset then idle: deassert reset_n, hold 100 cycles with start=0 -> led_out=0, busy=0, ram_sel=0, done never asserted.
- Single pixel, NUM_LEDS=1, RAM[0]=64'hFFFF_FFFF_00A5_0F81:
  - led_out high widths are 40,20,40,20,20,40,20,40, 20,20,20,20,40,40,40,40, 40,20,20,20,20,20,20,40;
  - each bit period is 63 cycles;
  - done falls exactly 1+1514+2500+1 cycles after start.
- Full frame, NUM_LEDS=16, RAM[i]=i:
  - ram_adr sequence is 0..15, one ram_sel pulse each, ram_we=0 throughout;
  - the inter-pixel low gap is exactly 2 extra cycles;
  - each pixel decodes to value i.
- start while busy: pulse start at pixel 3 and again during LATCH -> no restart, a single done pulse, adr sequence unchanged.
- Back-to-back: pulse start in the cycle after done -> second frame begins, FETCH of adr 0 on the next cycle.
- Reset mid-frame: assert reset_n during the high phase of pixel 5, bit 10 -> led_out=0 and busy=0 asynchronously, no done. A new start afterwards begins at adr 0.
